irrigation_pump_ctrl: RTL and testbench

Downstream stage of the fuzzy irrigation controller: converts its combinational `irrigation_time` (seconds) and `rain_present` outputs into a timed, one-shot pump drive. On a start strobe it latches the requested duration, runs the pump for that many seconds, and aborts immediately if rain appears. It then enforces a cooldown before accepting the next request. It is the only block that drives the pump/valve output.

---
 rtl/irrigation_pkg.sv | 15 +
 rtl/irrigation_pump_ctrl_if.sv | 26 ++
 rtl/irrigation_pump_ctrl_sec_tick_gen.sv | 29 ++
 rtl/irrigation_pump_ctrl.sv | 114 +++++++++++
 tb/tb_irrigation_pump_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation pump timing stage.
package irrigation_pkg;

  localparam int unsigned IRR_TIME_W = 8;

  localparam int unsigned DEF_TICKS_PER_SEC = 50_000_000;
  localparam logic [IRR_TIME_W-1:0] DEF_COOLDOWN_SEC = 8'd60;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_COOLDOWN = 2'd2
  } pump_state_t;

endpackage

// File: rtl/irrigation_pump_ctrl_if.sv
// Request/status bundle between the fuzzy stage and the pump controller.
interface irrigation_pump_ctrl_if;
  import irrigation_pkg::*;

  logic                  start;
  logic [IRR_TIME_W-1:0] irrigation_time;
  logic                  rain_present;
  logic                  pump_on;
  logic                  busy;
  logic [IRR_TIME_W-1:0] remaining_sec;
  logic                  done;
  logic                  aborted;
  logic                  skipped;
  logic [1:0]            state;

  modport master (
    output start, irrigation_time, rain_present,
    input  pump_on, busy, remaining_sec, done, aborted, skipped, state
  );

  modport slave (
    input  start, irrigation_time, rain_present,
    output pump_on, busy, remaining_sec, done, aborted, skipped, state
  );

endinterface

// File: rtl/irrigation_pump_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 and flags the last count.
module sec_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  // Tick decodes the registered count, so it is glitch-free and input-independent.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/irrigation_pump_ctrl.sv
// Timed one-shot pump drive with rain abort and post-run cooldown.
module irrigation_pump_ctrl
  import irrigation_pkg::*;
#(
  parameter int unsigned           TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter logic [IRR_TIME_W-1:0] COOLDOWN_SEC  = DEF_COOLDOWN_SEC
) (
  input logic                   clk,
  input logic                   reset,
  irrigation_pump_ctrl_if.slave bus
);

  pump_state_t           state_q, state_next;
  logic [IRR_TIME_W-1:0] rem_q, rem_next;
  logic                  done_next, aborted_next, skipped_next;
  logic                  tick, clear;

  logic                  pump_q, busy_q, done_q, aborted_q, skipped_q;

  // Restart the second count whenever the state changes so every first second is whole.
  assign clear = (state_next != state_q);

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_next   = state_q;
    rem_next     = rem_q;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    skipped_next = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rem_next = '0;
        if (bus.start) begin
          if (bus.irrigation_time == '0 || bus.rain_present) begin
            done_next    = 1'b1;
            skipped_next = 1'b1;
          end else begin
            state_next = ST_RUN;
            rem_next   = bus.irrigation_time;
          end
        end
      end
      ST_RUN: begin
        // Rain wins over a final tick landing in the same cycle.
        if (bus.rain_present) begin
          state_next   = ST_COOLDOWN;
          rem_next     = COOLDOWN_SEC;
          done_next    = 1'b1;
          aborted_next = 1'b1;
        end else if (tick) begin
          if (rem_q <= 8'd1) begin
            state_next = ST_COOLDOWN;
            rem_next   = COOLDOWN_SEC;
            done_next  = 1'b1;
          end else begin
            rem_next = rem_q - 8'd1;
          end
        end
      end
      ST_COOLDOWN: begin
        if (tick) begin
          if (rem_q <= 8'd1) begin
            state_next = ST_IDLE;
            rem_next   = '0;
          end else begin
            rem_next = rem_q - 8'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        rem_next   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      pump_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      rem_q     <= rem_next;
      pump_q    <= (state_next == ST_RUN);
      busy_q    <= (state_next == ST_RUN) || (state_next == ST_COOLDOWN);
      done_q    <= done_next;
      aborted_q <= aborted_next;
      skipped_q <= skipped_next;
    end
  end

  assign bus.pump_on       = pump_q;
  assign bus.busy          = busy_q;
  assign bus.remaining_sec = rem_q;
  assign bus.done          = done_q;
  assign bus.aborted       = aborted_q;
  assign bus.skipped       = skipped_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_irrigation_pump_ctrl.sv
// Directed, table-driven bench for irrigation_pump_ctrl with 4 ticks/s and 2 s cooldown.
module tb_irrigation_pump_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  irrigation_pump_ctrl_if ifc ();

  irrigation_pump_ctrl #(
    .TICKS_PER_SEC(4),
    .COOLDOWN_SEC (8'd2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: {pump, busy, rem[7:0], done, aborted, skipped, state[1:0]}.
  logic [14:0] obs;
  assign obs = {ifc.pump_on, ifc.busy, ifc.remaining_sec, ifc.done,
                ifc.aborted, ifc.skipped, ifc.state};

  typedef struct {
    logic        st;
    logic [7:0]  tm;
    logic        rn;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [14:0] e(input logic pump, input logic busy, input logic [7:0] rem,
                                    input logic done, input logic abt, input logic skp,
                                    input logic [1:0] st);
    return {pump, busy, rem, done, abt, skp, st};
  endfunction

  function automatic vec_t mkv(input logic st, input logic [7:0] tm, input logic rn,
                               input logic [14:0] exp);
    vec_t v;
    v.st = st; v.tm = tm; v.rn = rn; v.exp = exp;
    return v;
  endfunction

  task automatic apply_stimulus(input logic st, input logic [7:0] tm, input logic rn);
    ifc.start           = st;
    ifc.irrigation_time = tm;
    ifc.rain_present    = rn;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got pump=%b busy=%b rem=%0d done=%b abt=%b skp=%b st=%0d, want pump=%b busy=%b rem=%0d done=%b abt=%b skp=%b st=%0d",
               name, act[14], act[13], act[12:5], act[4], act[3], act[2], act[1:0],
               exp[14], exp[13], exp[12:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    ifc.start           = 1'b0;
    ifc.irrigation_time = 8'd0;
    ifc.rain_present    = 1'b0;

    // Normal 3 s run with stray starts, then cooldown, then skip cases.
    vecs[0]  = mkv(1, 8'd3,  0, e(1, 1, 8'd3, 0, 0, 0, 2'd1));
    vecs[1]  = mkv(0, 8'd0,  0, e(1, 1, 8'd3, 0, 0, 0, 2'd1));
    vecs[2]  = mkv(0, 8'd0,  0, e(1, 1, 8'd3, 0, 0, 0, 2'd1));
    vecs[3]  = mkv(0, 8'd0,  0, e(1, 1, 8'd3, 0, 0, 0, 2'd1));
    vecs[4]  = mkv(0, 8'd0,  0, e(1, 1, 8'd2, 0, 0, 0, 2'd1));
    vecs[5]  = mkv(1, 8'd7,  0, e(1, 1, 8'd2, 0, 0, 0, 2'd1));
    vecs[6]  = mkv(0, 8'd0,  0, e(1, 1, 8'd2, 0, 0, 0, 2'd1));
    vecs[7]  = mkv(0, 8'd0,  0, e(1, 1, 8'd2, 0, 0, 0, 2'd1));
    vecs[8]  = mkv(0, 8'd0,  0, e(1, 1, 8'd1, 0, 0, 0, 2'd1));
    vecs[9]  = mkv(0, 8'd0,  0, e(1, 1, 8'd1, 0, 0, 0, 2'd1));
    vecs[10] = mkv(0, 8'd0,  0, e(1, 1, 8'd1, 0, 0, 0, 2'd1));
    vecs[11] = mkv(0, 8'd0,  0, e(1, 1, 8'd1, 0, 0, 0, 2'd1));
    vecs[12] = mkv(0, 8'd0,  0, e(0, 1, 8'd2, 1, 0, 0, 2'd2));
    vecs[13] = mkv(1, 8'd5,  0, e(0, 1, 8'd2, 0, 0, 0, 2'd2));
    vecs[14] = mkv(0, 8'd0,  0, e(0, 1, 8'd2, 0, 0, 0, 2'd2));
    vecs[15] = mkv(0, 8'd0,  0, e(0, 1, 8'd2, 0, 0, 0, 2'd2));
    vecs[16] = mkv(0, 8'd0,  0, e(0, 1, 8'd1, 0, 0, 0, 2'd2));
    vecs[17] = mkv(0, 8'd0,  0, e(0, 1, 8'd1, 0, 0, 0, 2'd2));
    vecs[18] = mkv(0, 8'd0,  0, e(0, 1, 8'd1, 0, 0, 0, 2'd2));
    vecs[19] = mkv(0, 8'd0,  0, e(0, 1, 8'd1, 0, 0, 0, 2'd2));
    vecs[20] = mkv(0, 8'd0,  0, e(0, 0, 8'd0, 0, 0, 0, 2'd0));
    vecs[21] = mkv(1, 8'd0,  0, e(0, 0, 8'd0, 1, 0, 1, 2'd0));
    vecs[22] = mkv(1, 8'd45, 1, e(0, 0, 8'd0, 1, 0, 1, 2'd0));
    vecs[23] = mkv(0, 8'd0,  1, e(0, 0, 8'd0, 0, 0, 0, 2'd0));

    #3;
    check_output("reset_state", obs, e(0, 0, 8'd0, 0, 0, 0, 2'd0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      apply_stimulus(vecs[i].st, vecs[i].tm, vecs[i].rn);
      check_output($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Rain abort in the ninth RUN cycle of a 10 s request.
    apply_stimulus(1, 8'd10, 0);
    check_output("abort_start", obs, e(1, 1, 8'd10, 0, 0, 0, 2'd1));
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 8'd0, 0);
      check_output($sformatf("abort_run%0d", i), obs,
                   e(1, 1, (i < 3) ? 8'd10 : (i < 7) ? 8'd9 : 8'd8, 0, 0, 0, 2'd1));
    end
    apply_stimulus(0, 8'd0, 1);
    check_output("abort_hit", obs, e(0, 1, 8'd2, 1, 1, 0, 2'd2));
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(0, 8'd0, 1);
      check_output($sformatf("abort_cool%0d", i), obs,
                   e(0, 1, (i < 3) ? 8'd2 : 8'd1, 0, 0, 0, 2'd2));
    end
    apply_stimulus(0, 8'd0, 1);
    check_output("abort_idle", obs, e(0, 0, 8'd0, 0, 0, 0, 2'd0));

    // Start on the first IDLE cycle, then reset asynchronously mid-RUN.
    apply_stimulus(1, 8'd5, 0);
    check_output("rst_run_start", obs, e(1, 1, 8'd5, 0, 0, 0, 2'd1));
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 8'd0, 0);
      check_output($sformatf("rst_run%0d", i), obs,
                   e(1, 1, (i < 3) ? 8'd5 : 8'd4, 0, 0, 0, 2'd1));
    end
    #2 reset = 1'b0;
    #1 check_output("rst_async", obs, e(0, 0, 8'd0, 0, 0, 0, 2'd0));
    @(negedge clk);
    check_output("rst_hold", obs, e(0, 0, 8'd0, 0, 0, 0, 2'd0));
    reset = 1'b1;
    apply_stimulus(1, 8'd1, 0);
    check_output("one_sec_start", obs, e(1, 1, 8'd1, 0, 0, 0, 2'd1));
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 8'd0, 0);
      check_output($sformatf("one_sec_run%0d", i), obs, e(1, 1, 8'd1, 0, 0, 0, 2'd1));
    end
    apply_stimulus(0, 8'd0, 0);
    check_output("one_sec_done", obs, e(0, 1, 8'd2, 1, 0, 0, 2'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
